oppm_packet_decoder: RTL and testbench

- Receive-side counterpart of the OPPM packet encoder.
- Hunts for the preamble (PRE_CT value-0 symbols) on a single pulse line and locks symbol timing to the preamble edges.
- Demodulates ceil(N_PKT/N_MOD) data symbols MSB-first into an N_PKT packet and presents it with a sticky avail/read handshake.
- Adds preamble phase tracking, edge-timing tolerance, missing/duplicate-symbol error detection and overrun reporting.

---
 rtl/oppm_packet_decoder.sv | 169 ++++++++++++++++
 tb/tb_oppm_packet_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/oppm_packet_decoder.sv
// oppm_packet_decoder: OPPM receiver that locks to the preamble, demodulates
// data symbols into a packet and offers it through a sticky avail/read handshake.
module oppm_packet_decoder #(
    parameter int N_MOD  = 2,
    parameter int L      = 8,
    parameter int N_PKT  = 8,
    parameter int PRE_CT = 4,
    parameter int TOL    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse,
    input  logic             read,
    output logic [N_PKT-1:0] data,
    output logic             avail,
    output logic             busy,
    output logic             err,
    output logic             overrun
);
    localparam int SYM_CT   = L << N_MOD;
    localparam int DATA_SYM = (N_PKT + N_MOD - 1) / N_MOD;
    localparam int SH_W     = DATA_SYM * N_MOD;
    localparam int SC_W     = $clog2(SYM_CT + TOL + 2);
    localparam int PC_W     = $clog2(PRE_CT + 1);
    localparam int K_W      = $clog2(DATA_SYM + 1);
    localparam int LT_W     = $clog2(L + 1);
    localparam logic [SC_W-1:0] SC_LO    = SC_W'(SYM_CT - TOL);
    localparam logic [SC_W-1:0] SC_HI    = SC_W'(SYM_CT + TOL);
    localparam logic [SC_W-1:0] SC_SAT   = SC_W'(SYM_CT + TOL + 1);
    localparam logic [SC_W-1:0] LEAD_END = SC_W'(SYM_CT - TOL - 1);
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PRE_CT - 1);
    localparam logic [K_W-1:0]  K_LAST   = K_W'(DATA_SYM - 1);
    localparam logic [LT_W-1:0] LT_LAST  = LT_W'(L - 1);

    typedef enum logic [1:0] {HUNT, PREAM, DATA} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sync_q;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              lead_q, lead_d;
    logic [LT_W-1:0]   lt_q, lt_d;
    logic [N_MOD-1:0]  slot_q, slot_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              got_q, got_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [N_PKT-1:0]  data_q, data_d;
    logic              avail_q, avail_d;
    logic              ovr_q, ovr_d;
    logic              rise, lt_wrap, win_end, got_n, err_c;
    logic [SH_W-1:0]   sh_n;

    assign rise    = sync_q[1] & ~sync_q[2];
    assign lt_wrap = lt_q == LT_LAST;
    assign win_end = lt_wrap && slot_q == '1;
    assign got_n   = got_q | rise;
    assign sh_n    = rise ? SH_W'({sh_q, slot_q}) : sh_q;

    always_comb begin
        state_d = state_q;
        sc_d    = (sc_q == SC_SAT) ? sc_q : sc_q + 1'b1;
        pc_d    = pc_q;
        lead_d  = lead_q;
        lt_d    = lt_wrap ? '0 : lt_q + 1'b1;
        slot_d  = lt_wrap ? slot_q + 1'b1 : slot_q;
        k_d     = k_q;
        got_d   = got_q;
        sh_d    = sh_q;
        data_d  = data_q;
        avail_d = avail_q & ~read;
        ovr_d   = 1'b0;
        err_c   = 1'b0;
        case (state_q)
            HUNT: begin
                if (rise) begin
                    state_d = PREAM;
                    pc_d    = PC_W'(1);
                    sc_d    = SC_W'(1);
                end
            end
            PREAM: begin
                if (rise && sc_q >= SC_LO && sc_q <= SC_HI) begin
                    pc_d = pc_q + 1'b1;
                    sc_d = SC_W'(1);
                    if (pc_q == PC_LAST) begin
                        state_d = DATA;
                        lead_d  = 1'b1;
                    end
                end else if (rise && sc_q < SC_LO) begin
                    pc_d = PC_W'(1);
                    sc_d = SC_W'(1);
                end else if (sc_q > SC_HI) begin
                    state_d = HUNT;
                end
            end
            DATA: begin
                // lead-in holds the slot counters at zero until window 0 opens TOL ticks early
                if (lead_q) begin
                    lt_d   = '0;
                    slot_d = '0;
                    k_d    = '0;
                    got_d  = 1'b0;
                    lead_d = sc_q != LEAD_END;
                end else if (rise && got_q) begin
                    err_c   = 1'b1;
                    state_d = HUNT;
                end else begin
                    sh_d  = sh_n;
                    got_d = got_n;
                    if (win_end) begin
                        got_d = 1'b0;
                        k_d   = k_q + 1'b1;
                        if (!got_n) begin
                            err_c   = 1'b1;
                            state_d = HUNT;
                        end else if (k_q == K_LAST) begin
                            state_d = HUNT;
                            if (!avail_q || read) begin
                                data_d  = sh_n[SH_W-1 -: N_PKT];
                                avail_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            sync_q  <= '0;
            sc_q    <= '0;
            pc_q    <= '0;
            lead_q  <= 1'b0;
            lt_q    <= '0;
            slot_q  <= '0;
            k_q     <= '0;
            got_q   <= 1'b0;
            sh_q    <= '0;
            data_q  <= '0;
            avail_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[1:0], pulse};
            sc_q    <= sc_d;
            pc_q    <= pc_d;
            lead_q  <= lead_d;
            lt_q    <= lt_d;
            slot_q  <= slot_d;
            k_q     <= k_d;
            got_q   <= got_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            avail_q <= avail_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data    = data_q;
    assign avail   = avail_q;
    assign busy    = state_q != HUNT;
    assign err     = err_c & ~rst;
    assign overrun = ovr_q;
endmodule

// File: tb/tb_oppm_packet_decoder.sv
// tb_oppm_packet_decoder: table-driven edge schedules against hand-computed packet results.
module tb_oppm_packet_decoder;
    logic clk = 1'b0, rst = 1'b1, pulse = 1'b0, read = 1'b0;
    logic [7:0] data2, data3;
    logic avail2, busy2, err2, ovr2, avail3, busy3, err3, ovr3;
    int checks = 0, errors = 0;
    localparam logic [9:0] NO = 10'h3FF;

    typedef struct packed {
        logic             wide;
        logic [15:0][9:0] ev;
        logic [9:0]       rst_c, rd_lo, rd_hi, pre_c, chk_c, err_c, last;
        logic             pre_avail, pre_busy;
        logic [7:0]       data;
        logic             avail, busy;
        logic [3:0]       err_n, ovr_n;
    } vec_t;

    vec_t tv[13];

    always #5 clk = ~clk;

    oppm_packet_decoder dut (
        .clk(clk), .rst(rst), .pulse(pulse), .read(read),
        .data(data2), .avail(avail2), .busy(busy2), .err(err2), .overrun(ovr2)
    );

    oppm_packet_decoder #(.N_MOD(3)) dut3 (
        .clk(clk), .rst(rst), .pulse(pulse), .read(read),
        .data(data3), .avail(avail3), .busy(busy3), .err(err3), .overrun(ovr3)
    );

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    function automatic bit hit(input vec_t v, input int c);
        for (int j = 0; j < 16; j++)
            if (v.ev[j] != NO && int'(v.ev[j]) == c) return 1'b1;
        return 1'b0;
    endfunction

    // cycle k is the cycle in which a detected edge scheduled at k is seen by the decoder
    task automatic run(input int i);
        vec_t v;
        int ef, en, on;
        logic [7:0] d;
        logic a, b, e, o;
        v = tv[i];
        ef = -1;
        en = 0;
        on = 0;
        rst = 1'b1;
        pulse = 1'b0;
        read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = -2; k <= int'(v.last); k++) begin
            pulse = hit(v, k + 2) || hit(v, k + 1);
            read  = k >= int'(v.rd_lo) && k <= int'(v.rd_hi);
            rst   = k == int'(v.rst_c);
            @(negedge clk);
            d = v.wide ? data3 : data2;
            a = v.wide ? avail3 : avail2;
            b = v.wide ? busy3 : busy2;
            e = v.wide ? err3 : err2;
            o = v.wide ? ovr3 : ovr2;
            if (e) begin
                if (ef < 0) ef = k;
                en++;
            end
            if (o) on++;
            if (k == int'(v.pre_c)) begin
                chk($sformatf("v%0d pre_avail@%0d", i, k), int'(a), int'(v.pre_avail));
                chk($sformatf("v%0d pre_busy@%0d", i, k), int'(b), int'(v.pre_busy));
            end
            if (k == int'(v.chk_c)) begin
                chk($sformatf("v%0d data@%0d", i, k), int'(d), int'(v.data));
                chk($sformatf("v%0d avail@%0d", i, k), int'(a), int'(v.avail));
                chk($sformatf("v%0d busy@%0d", i, k), int'(b), int'(v.busy));
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        pulse = 1'b0;
        read = 1'b0;
        chk($sformatf("v%0d err_first_cycle", i), ef, (v.err_c == NO) ? -1 : int'(v.err_c));
        chk($sformatf("v%0d err_count", i), en, int'(v.err_n));
        chk($sformatf("v%0d overrun_count", i), on, int'(v.ovr_n));
    endtask

    initial begin
        // clean 0xB4
        tv[0] = '{wide:0, ev:{10'd0,10'd32,10'd64,10'd96,10'd144,10'd184,10'd200,10'd224,{8{NO}}},
                  rst_c:NO, rd_lo:NO, rd_hi:NO, pre_c:254, pre_avail:0, pre_busy:1, chk_c:255,
                  data:8'hB4, avail:1, busy:0, err_c:NO, err_n:0, ovr_n:0, last:270};
        // preamble jitter +1, first data edge one tick early
        tv[1] = '{wide:0, ev:{10'd0,10'd33,10'd65,10'd97,10'd144,10'd185,10'd201,10'd225,{8{NO}}},
                  rst_c:NO, rd_lo:NO, rd_hi:NO, pre_c:255, pre_avail:0, pre_busy:1, chk_c:256,
                  data:8'hB4, avail:1, busy:0, err_c:NO, err_n:0, ovr_n:0, last:270};
        // preamble jitter +1, first data edge one tick late
        tv[2] = '{wide:0, ev:{10'd0,10'd33,10'd65,10'd97,10'd146,10'd185,10'd201,10'd225,{8{NO}}},
                  rst_c:NO, rd_lo:NO, rd_hi:NO, pre_c:255, pre_avail:0, pre_busy:1, chk_c:256,
                  data:8'hB4, avail:1, busy:0, err_c:NO, err_n:0, ovr_n:0, last:270};
        // edge at 35 is too late: preamble restarts there, lock at 131
        tv[3] = '{wide:0, ev:{10'd0,10'd35,10'd67,10'd99,10'd131,10'd179,10'd219,10'd235,10'd259,{7{NO}}},
                  rst_c:NO, rd_lo:NO, rd_hi:NO, pre_c:289, pre_avail:0, pre_busy:1, chk_c:290,
                  data:8'hB4, avail:1, busy:0, err_c:NO, err_n:0, ovr_n:0, last:300};
        // edge at 20 is too early: preamble restarts there, lock at 116
        tv[4] = '{wide:0, ev:{10'd0,10'd20,10'd52,10'd84,10'd116,10'd164,10'd204,10'd220,10'd244,{7{NO}}},
                  rst_c:NO, rd_lo:NO, rd_hi:NO, pre_c:274, pre_avail:0, pre_busy:1, chk_c:275,
                  data:8'hB4, avail:1, busy:0, err_c:NO, err_n:0, ovr_n:0, last:290};
        // preamble edge exactly SYM_CT-TOL after the first
        tv[5] = '{wide:0, ev:{10'd0,10'd31,10'd63,10'd95,10'd143,10'd183,10'd199,10'd223,{8{NO}}},
                  rst_c:NO, rd_lo:NO, rd_hi:NO, pre_c:253, pre_avail:0, pre_busy:1, chk_c:254,
                  data:8'hB4, avail:1, busy:0, err_c:NO, err_n:0, ovr_n:0, last:270};
        // symbol 1 missing
        tv[6] = '{wide:0, ev:{10'd0,10'd32,10'd64,10'd96,10'd144,10'd200,10'd224,{9{NO}}},
                  rst_c:NO, rd_lo:NO, rd_hi:NO, pre_c:191, pre_avail:0, pre_busy:0, chk_c:300,
                  data:8'h00, avail:0, busy:0, err_c:190, err_n:1, ovr_n:0, last:300};
        // duplicate edge in window 0
        tv[7] = '{wide:0, ev:{10'd0,10'd32,10'd64,10'd96,10'd144,10'd150,10'd184,10'd200,10'd224,{7{NO}}},
                  rst_c:NO, rd_lo:NO, rd_hi:NO, pre_c:151, pre_avail:0, pre_busy:0, chk_c:300,
                  data:8'h00, avail:0, busy:0, err_c:150, err_n:1, ovr_n:0, last:300};
        // back-to-back 0xB4 then 0x1E, no read: overrun
        tv[8] = '{wide:0, ev:{10'd0,10'd32,10'd64,10'd96,10'd144,10'd184,10'd200,10'd224,
                              10'd256,10'd288,10'd320,10'd352,10'd384,10'd424,10'd472,10'd496},
                  rst_c:NO, rd_lo:NO, rd_hi:NO, pre_c:510, pre_avail:1, pre_busy:1, chk_c:511,
                  data:8'hB4, avail:1, busy:0, err_c:NO, err_n:0, ovr_n:1, last:530};
        // same, read during the completion: new packet taken, no overrun
        tv[9] = '{wide:0, ev:{10'd0,10'd32,10'd64,10'd96,10'd144,10'd184,10'd200,10'd224,
                              10'd256,10'd288,10'd320,10'd352,10'd384,10'd424,10'd472,10'd496},
                  rst_c:NO, rd_lo:510, rd_hi:511, pre_c:510, pre_avail:1, pre_busy:1, chk_c:511,
                  data:8'h1E, avail:1, busy:0, err_c:NO, err_n:0, ovr_n:0, last:530};
        // read clears avail, data kept
        tv[10] = '{wide:0, ev:{10'd0,10'd32,10'd64,10'd96,10'd144,10'd184,10'd200,10'd224,{8{NO}}},
                   rst_c:NO, rd_lo:260, rd_hi:260, pre_c:260, pre_avail:1, pre_busy:0, chk_c:261,
                   data:8'hB4, avail:0, busy:0, err_c:NO, err_n:0, ovr_n:0, last:270};
        // reset mid-packet, then a clean 0x1E locked at 276
        tv[11] = '{wide:0, ev:{10'd0,10'd32,10'd64,10'd96,10'd144,10'd180,10'd212,10'd244,10'd276,
                               10'd308,10'd348,10'd396,10'd420,{3{NO}}},
                   rst_c:170, rd_lo:NO, rd_hi:NO, pre_c:171, pre_avail:0, pre_busy:0, chk_c:435,
                   data:8'h1E, avail:1, busy:0, err_c:NO, err_n:0, ovr_n:0, last:450};
        // N_MOD=3: symbols 5,1,2 with one pad bit -> 0xA5
        tv[12] = '{wide:1, ev:{10'd0,10'd64,10'd128,10'd192,10'd296,10'd328,10'd400,{9{NO}}},
                   rst_c:NO, rd_lo:NO, rd_hi:NO, pre_c:446, pre_avail:0, pre_busy:1, chk_c:447,
                   data:8'hA5, avail:1, busy:0, err_c:NO, err_n:0, ovr_n:0, last:470};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset data", int'(data2), 0);
        chk("reset avail", int'(avail2), 0);
        chk("reset busy", int'(busy2), 0);
        chk("reset err", int'(err2), 0);
        chk("reset overrun", int'(ovr2), 0);
        chk("reset busy n3", int'(busy3), 0);
        read = 1'b1;
        repeat (3) @(posedge clk);
        #1 read = 1'b0;
        @(negedge clk);
        chk("idle read avail", int'(avail2), 0);
        chk("idle read busy", int'(busy2), 0);

        for (int i = 0; i < 13; i++) run(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
